// File: rtl/datap_pkg.sv
// Shared constants for the datap multiply/add pipeline: func encodings and default width.
package datap_pkg;

  localparam int unsigned DATAP_BITS = 32;

  localparam logic [1:0] FUNC_MUL = 2'b00;
  localparam logic [1:0] FUNC_ADD = 2'b01;
  localparam logic [1:0] FUNC_MAC = 2'b10;
  localparam logic [1:0] FUNC_ACC = 2'b11;

endpackage

// File: rtl/datap_mul.sv
// Combinational unsigned bits x bits -> 2*bits multiplier feeding datap stage 1.
module datap_mul
  import datap_pkg::*;
#(
  parameter int unsigned bits = DATAP_BITS
) (
  input  logic [bits-1:0]   a_i,
  input  logic [bits-1:0]   b_i,
  output logic [2*bits-1:0] p_o
);

  assign p_o = {{bits{1'b0}}, a_i} * {{bits{1'b0}}, b_i};

endmodule

// File: rtl/datap.sv
// Two-stage multiply/add datapath: stage 1 registers A*B, A, C, func; stage 2 selects the result.
// Build option: define DATAP_ACC_EN to make func 11 accumulate result + mult_out_reg (else hold).
module datap
  import datap_pkg::*;
#(
  parameter int unsigned bits = DATAP_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        func,
  input  logic [bits-1:0]   A,
  input  logic [bits-1:0]   B,
  input  logic [bits-1:0]   C,
  output logic [2*bits-1:0] result,
  output logic [1:0]        func_reg,
  output logic [2*bits-1:0] mult_out_reg,
  output logic [bits-1:0]   c_reg
);

  logic [2*bits-1:0] prod;
  logic [2*bits-1:0] mult_q;
  logic [bits-1:0]   a_q;
  logic [bits-1:0]   c_q;
  logic [1:0]        func_q;
  logic [2*bits-1:0] result_q;
  logic [2*bits-1:0] result_d;

  datap_mul #(.bits(bits)) u_mul (
    .a_i (A),
    .b_i (B),
    .p_o (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_q <= '0;
      a_q    <= '0;
      c_q    <= '0;
      func_q <= FUNC_MUL;
    end else begin
      mult_q <= prod;
      a_q    <= A;
      c_q    <= C;
      func_q <= func;
    end
  end

  // Operands are zero-extended to 2*bits so the add carry lands in bit `bits`.
  always_comb begin
    result_d = result_q;
    case (func_q)
      FUNC_MUL: result_d = mult_q;
      FUNC_ADD: result_d = {{bits{1'b0}}, a_q} + {{bits{1'b0}}, c_q};
      FUNC_MAC: result_d = mult_q + {{bits{1'b0}}, c_q};
      FUNC_ACC: begin
`ifdef DATAP_ACC_EN
        result_d = result_q + mult_q;
`else
        result_d = result_q;
`endif
      end
      default:  result_d = result_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result       = result_q;
  assign func_reg     = func_q;
  assign mult_out_reg = mult_q;
  assign c_reg        = c_q;

endmodule

// File: tb/tb_datap.sv
// Scoreboard bench for datap: stimulus pushes expected stage-1 and result values, a monitor pops them.
module tb_datap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  func = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] C = '0;
  logic [63:0] result;
  logic [1:0]  func_reg;
  logic [63:0] mult_out_reg;
  logic [31:0] c_reg;

  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct {
    logic [1:0]  f;
    logic [63:0] mul;
    logic [31:0] c;
  } s1_t;

  s1_t         s1_q[$];
  logic [63:0] s2_q[$];
  logic [63:0] prev_res = '0;
  int          pending = 0;

  datap #(.bits(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .func         (func),
    .A            (A),
    .B            (B),
    .C            (C),
    .result       (result),
    .func_reg     (func_reg),
    .mult_out_reg (mult_out_reg),
    .c_reg        (c_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the operation means arithmetically, on 64-bit values.
  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    logic [63:0] m;
    logic [63:0] r;
    m = {32'b0, a} * {32'b0, b};
    case (f)
      2'd0:    r = m;
      2'd1:    r = {32'b0, a} + {32'b0, c};
      2'd2:    r = m + {32'b0, c};
      default: begin
`ifdef DATAP_ACC_EN
        r = prev_res + m;
`else
        r = prev_res;
`endif
      end
    endcase
    @(negedge clk);
    func = f; A = a; B = b; C = c;
    prev_res = r;
    s1_q.push_back('{f: f, mul: m, c: c});
    s2_q.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, result, 64'd0);
    check({tag, "_mult"}, mult_out_reg, 64'd0);
    check({tag, "_creg"}, {32'd0, c_reg}, 64'd0);
    check({tag, "_func"}, {62'd0, func_reg}, 64'd0);
  endtask

  // Release right after an edge so the very next edge samples the first issued op.
  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pending = 0;
    end else begin
      if (pending > 0) begin
        if (s2_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          check("result", result, s2_q.pop_front());
        end
        pending--;
      end
      if (s1_q.size() > 0) begin
        s1_t e;
        e = s1_q.pop_front();
        check("mult_out_reg", mult_out_reg, e.mul);
        check("c_reg", {32'd0, c_reg}, {32'd0, e.c});
        check("func_reg", {62'd0, func_reg}, {62'd0, e.f});
        pending++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #3;
    check_all_zero("reset");
    release_reset();

    issue(2'd0, 32'd2, 32'd7, 32'd1);
    issue(2'd1, 32'd2, 32'd7, 32'd1);
    issue(2'd2, 32'd2, 32'd7, 32'd1);
    issue(2'd0, 32'd3, 32'd4, 32'd2);
    issue(2'd1, 32'd3, 32'd4, 32'd2);
    issue(2'd2, 32'd3, 32'd4, 32'd2);
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'd0, 32'd2, 32'd7, 32'd0);
    for (int i = 0; i < 3; i++) issue(2'd3, 32'd2, 32'd7, 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      a = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      b = (i % 11 == 0) ? 32'hFFFF_FFFF : $urandom;
      c = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      issue(2'($urandom_range(3, 0)), a, b, c);
    end

    // Mid-cycle asynchronous reset discards both in-flight stages.
    issue(2'd2, 32'd9, 32'd9, 32'd9);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    s1_q.delete();
    s2_q.delete();
    prev_res = '0;
    func = 2'd0; A = '0; B = '0; C = '0;
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("rst_held");
    release_reset();
    issue(2'd0, 32'd2, 32'd7, 32'd0);
    issue(2'd3, 32'd2, 32'd7, 32'd0);
    issue(2'd1, 32'd2, 32'd7, 32'd5);

    repeat (3) @(posedge clk);
    #3;
    check("sb_drained", 64'(s1_q.size() + s2_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datap.md
# datap

Two-stage pipelined multiply/add datapath for the multiply-accumulate block. Each cycle it registers operands A, B, C and an operation code. It then produces A*B, A+C or A*B+C as a double-width registered result one cycle later. It sits under the MAC controller, which drives `func` and the operands every cycle; it has no handshake.

## Interface
- `bits`, default 32, operand width; result width is 2*bits.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `func` input 2: operation code; 00 = A*B, 01 = A+C, 10 = A*B+C, 11 = reserved (see Configuration).
- `A` input bits: operand A, unsigned.
- `B` input bits: operand B, unsigned.
- `C` input bits: operand C, unsigned.
- `result` output 2*bits: registered stage-2 result.
- `func_reg` output 2: stage-1 registered `func`.
- `mult_out_reg` output 2*bits: stage-1 registered A*B.
- `c_reg` output bits: stage-1 registered C.

## Operation
- Stage 1, at each rising edge:
  - `mult_out_reg` <= A*B, a full 2*bits unsigned product.
  - `c_reg` <= C.
  - internal `a_reg` <= A.
  - `func_reg` <= func.
- Stage 2, at each rising edge, selected by `func_reg`:
  - 00: `result` <= `mult_out_reg`.
  - 01: `result` <= zero-extend(`a_reg`) + zero-extend(`c_reg`); the carry out lands in bit `bits`.
  - 10: `result` <= `mult_out_reg` + zero-extend(`c_reg`). This cannot overflow; the maximum is 2^(2*bits) - 2^bits.
  - 11: `result` holds its value, unless `DATAP_ACC_EN` is defined.
- All arithmetic is unsigned; no saturation, no flags.
- Every stage-1 register is rewritten every cycle; there is no enable.

## Timing
- Reset (`rst_n` = 0) asynchronously clears all outputs and `a_reg` to 0, independent of `clk`:
  - `result` = 0, `mult_out_reg` = 0, `c_reg` = 0, `func_reg` = 00.
  - After reset, `func_reg` = 00, so the first stage-2 update copies `mult_out_reg`.
- Latency:
  - Inputs sampled at edge k appear on the stage-1 outputs after edge k.
  - The corresponding `result` appears after edge k+1, i.e. 2 edges from input to result.
- Throughput is one operation per cycle. Back-to-back changes of `func` are independent: each result uses only its own stage-1 snapshot.
- Reset asserted mid-operation discards both in-flight stages. After release, the first valid `result` comes 2 edges after new inputs.
- Operands changing between edges have no effect; only values at the rising edge matter.

## Configuration
- Macro `DATAP_ACC_EN`.
- Defined: `func` 11 = accumulate, `result` <= `result` + `mult_out_reg`, modulo 2^(2*bits). Repeated 11 codes keep accumulating.
- Undefined: `func` 11 = no-op; `result` holds.
- In both cases the stage-1 behaviour for code 11 is unchanged.

## Structure
- Shared package `datap_pkg` holds:
  - the `func` encodings as localparams: FUNC_MUL = 2'b00, FUNC_ADD = 2'b01, FUNC_MAC = 2'b10, FUNC_ACC = 2'b11;
  - the default width constant, 32.
- One sub-module, `datap_mul`: a purely combinational bits x bits -> 2*bits unsigned multiplier. Stage 1 registers its output; a pipelined or DSP implementation can be swapped in later.
- Stage-2 adder and mux stay in `datap`.

## Test plan
- Reset, then A=2, B=7, C=1 with func 00, 01, 10 on consecutive cycles:
  - `mult_out_reg` = 14 and `c_reg` = 1 after the first edge;
  - `result` = 14, 3, 15 on the edges following each stage-1 capture.
- A=3, B=4, C=2 with func 00, 01, 10 back-to-back: `result` = 12, 5, 14; `func_reg` tracks func delayed by one cycle.
- A = B = C = 0xFFFFFFFF:
  - func 10 -> `result` = 0xFFFFFFFF_00000000;
  - func 01 -> `result` = 0x1_FFFFFFFE.
- Assert `rst_n` low mid-stream, between edges: all outputs read 0 immediately, before the next edge. After release, A=2, B=7 with func 00 -> `result` = 14 two edges later.
- Without the macro: set `result` = 14 (A=2, B=7, func 00), then func 11 for 3 cycles -> `result` stays 14.
- With `DATAP_ACC_EN`: A=2, B=7 held, func 00 then func 11 for 3 cycles -> `result` = 14, 28, 42, 56.
